rapid_mem_arbiter: RTL and testbench
====================================

Name: rapid_mem_arbiter

Overview:
Downstream of the RAPID-X core. Merges the core's instruction-fetch port and data (mmu) port onto one single-ported RAM/bus interface with an ack handshake. Returns fetched instructions and load data to the core. Raises per-port ready signals that drive the core's pipeline-enable.
Keeps a one-entry instruction line buffer so that repeated fetches of the same word do not occupy the bus.

Parameters:
XLEN, 32, data/instruction word width
ADDR_W, 32, byte address width; low 2 bits ignored (word aligned)
ACK_TIMEOUT, 15, max cycles to wait for i_ram_ack before abort (4-bit counter)

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-low reset
i_if_address  in  ADDR_W  instruction fetch address from core
i_if_req  in  1  fetch request, level, held until o_if_valid
o_if_data  out  XLEN  fetched instruction
o_if_valid  out  1  o_if_data valid for i_if_address this cycle
i_mmu_address  in  ADDR_W  data address
i_mmu_output_data  in  XLEN  store data
i_mmu_we  in  1  store request
i_mmu_re  in  1  load request (we and re mutually exclusive; we wins if both)
o_mmu_input_data  out  XLEN  load data
o_mmu_ready  out  1  data access complete / port idle
o_ram_addr  out  ADDR_W  RAM word address (byte addr, low 2 bits forced 0)
o_ram_wdata  out  XLEN  RAM write data
o_ram_en  out  1  RAM access strobe, held until ack
o_ram_we  out  1  write qualifier
i_ram_rdata  in  XLEN  RAM read data, valid with ack
i_ram_ack  in  1  access complete
o_bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values (async, i_reset=0):
  - State IDLE; all outputs 0, except o_mmu_ready=1.
  - Line buffer invalid. Round-robin pointer = DATA. Timeout counter 0.
- FSM states:
  - IDLE: no bus activity.
  - DATA: data access in flight.
  - INSTR: instruction access in flight.
  - DONE_D: one cycle; data result presented.
  - DONE_I: one cycle; instruction result presented.
- Line buffer hit (combinational):
  - Condition: buffer valid, tag == i_if_address[ADDR_W-1:2], no store to the same word pending this cycle.
  - o_if_valid=1 and o_if_data=buffer in the same cycle; no bus access.
- IDLE arbitration:
  - A data request is pending if i_mmu_we or i_mmu_re is asserted.
  - An instruction request is pending if i_if_req is asserted and the line buffer misses.
  - Only one pending: go to its state.
  - Both pending: serve the side the RR pointer names, then flip the pointer to the other side.
  - Single grants also set the pointer to the other side.
- Data request handling:
  - A data request forces o_mmu_ready=0 combinationally in the same cycle.
  - o_mmu_ready stays 0 until DONE_D.
- DATA/INSTR bus cycle:
  - Registered o_ram_en=1 from the cycle after grant.
  - Address, wdata and we are registered at grant and held stable until ack.
  - Leave on the first cycle i_ram_ack=1.
- Ack capture: on ack, capture i_ram_rdata.
  - DATA: capture into o_mmu_input_data (loads only; stores leave it unchanged).
  - INSTR: capture into o_if_data and the line buffer; buffer tag set, buffer valid.
- DONE_D: o_mmu_ready=1 for this cycle; return to IDLE.
- DONE_I: o_if_valid=1 for this cycle; return to IDLE.
- Minimum latency: grant to ready/valid = 3 cycles with ack on the first en cycle.
- Store coherency: any store whose word address equals the buffer tag invalidates the buffer.
  - Invalidation happens at grant, so a later fetch of that word re-reads RAM.
- Timeout:
  - The counter increments each en cycle without ack.
  - At ACK_TIMEOUT: drop o_ram_en and pulse o_bus_error for 1 cycle.
  - Then go to DONE_x with data 0x0000_0013 (NOP) for instruction, or 0 for load.
- Ack outside DATA/INSTR is ignored.
- Request deasserted mid-access: the access still completes; the result is discarded only for instruction (no o_if_valid) and the buffer is still filled.
- Reset mid-access: abort immediately; o_ram_en=0 asynchronously.

Test Plan:
1. Fetch 0x100, RAM acks after 2 cycles with 0x00A00093 -> o_ram_addr=0x100, o_if_valid one cycle with 0x00A00093; refetch 0x100 -> o_if_valid same cycle, o_ram_en stays 0.
2. Simultaneous fetch 0x104 and load 0x2000 from reset -> data served first (pointer=DATA), o_mmu_ready=1 with RAM value, then instruction access; repeat both -> instruction served first.
3. Store 0xDEADBEEF to 0x100 after scenario 1 -> o_ram_we=1, wdata=0xDEADBEEF; next fetch 0x100 misses and goes to bus.
4. Load with i_ram_ack never asserted -> o_ram_en high 15 cycles, o_bus_error pulse, o_mmu_ready=1, o_mmu_input_data=0.
5. Assert i_reset=0 during INSTR with en high -> o_ram_en=0 immediately, o_mmu_ready=1, buffer invalid; after release a fetch of the buffered address goes to bus.
6. Back-to-back loads 0x10,0x14 with ack each first en cycle -> each completes in 3 cycles, o_ram_addr low bits always 00.

Source files
------------

// File: rtl/rapid_mem_arbiter.sv
// Instruction-fetch / data-port arbiter onto one acked RAM bus,
// with a one-word instruction line buffer and an ack timeout.
module rapid_mem_arbiter #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_if_address,
   input  logic              i_if_req,
   output logic [XLEN-1:0]   o_if_data,
   output logic              o_if_valid,
   input  logic [ADDR_W-1:0] i_mmu_address,
   input  logic [XLEN-1:0]   i_mmu_output_data,
   input  logic              i_mmu_we,
   input  logic              i_mmu_re,
   output logic [XLEN-1:0]   o_mmu_input_data,
   output logic              o_mmu_ready,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [XLEN-1:0]   o_ram_wdata,
   output logic              o_ram_en,
   output logic              o_ram_we,
   input  logic [XLEN-1:0]   i_ram_rdata,
   input  logic              i_ram_ack,
   output logic              o_bus_error
);
   localparam int TW = ADDR_W - 2;
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
   localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DATA, S_INSTR, S_DONE_D, S_DONE_I
   } state_t;

   state_t          state_q, state_d;
   logic            rr_q, rr_d;
   logic            buf_v_q, buf_v_d;
   logic [TW-1:0]   buf_tag_q, buf_tag_d;
   logic [XLEN-1:0] buf_data_q, buf_data_d;
   logic            ram_en_q, ram_en_d;
   logic            ram_we_q, ram_we_d;
   logic [TW-1:0]   ram_tag_q, ram_tag_d;
   logic [XLEN-1:0] ram_wdata_q, ram_wdata_d;
   logic [XLEN-1:0] ld_data_q, ld_data_d;
   logic [XLEN-1:0] if_data_q, if_data_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            bus_err_q, bus_err_d;

   logic [TW-1:0] if_tag, mmu_tag;
   logic          d_req, st_clash, hit, i_req;
   logic          unused_lsbs;

   assign if_tag      = i_if_address[ADDR_W-1:2];
   assign mmu_tag     = i_mmu_address[ADDR_W-1:2];
   assign unused_lsbs = ^{i_if_address[1:0], i_mmu_address[1:0]};
   assign d_req       = i_mmu_we | i_mmu_re;
   // a store to the buffered word makes the buffer untrustworthy now
   assign st_clash    = i_mmu_we && (mmu_tag == buf_tag_q);
   assign hit         = buf_v_q && (if_tag == buf_tag_q) && !st_clash;
   assign i_req       = i_if_req && !hit;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      buf_v_d     = buf_v_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_tag_d   = ram_tag_q;
      ram_wdata_d = ram_wdata_q;
      ld_data_d   = ld_data_q;
      if_data_d   = if_data_q;
      cnt_d       = cnt_q;
      bus_err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // rr_q=0 favours the data side on contention
            if (d_req && !(i_req && rr_q)) begin
               state_d     = S_DATA;
               rr_d        = 1'b1;
               ram_en_d    = 1'b1;
               ram_we_d    = i_mmu_we;
               ram_tag_d   = mmu_tag;
               ram_wdata_d = i_mmu_output_data;
               cnt_d       = 4'd0;
               if (st_clash) buf_v_d = 1'b0;
            end else if (i_req) begin
               state_d   = S_INSTR;
               rr_d      = 1'b0;
               ram_en_d  = 1'b1;
               ram_we_d  = 1'b0;
               ram_tag_d = if_tag;
               cnt_d     = 4'd0;
            end
         end
         S_DATA, S_INSTR: begin
            if (i_ram_ack) begin
               ram_en_d = 1'b0;
               if (state_q == S_DATA) begin
                  state_d = S_DONE_D;
                  if (!ram_we_q) ld_data_d = i_ram_rdata;
               end else begin
                  state_d    = S_DONE_I;
                  if_data_d  = i_ram_rdata;
                  buf_data_d = i_ram_rdata;
                  buf_tag_d  = ram_tag_q;
                  buf_v_d    = 1'b1;
               end
            end else if (cnt_q == TO_LAST) begin
               ram_en_d  = 1'b0;
               bus_err_d = 1'b1;
               cnt_d     = 4'd0;
               if (state_q == S_DATA) begin
                  state_d = S_DONE_D;
                  if (!ram_we_q) ld_data_d = '0;
               end else begin
                  state_d   = S_DONE_I;
                  if_data_d = NOP;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE_D, S_DONE_I: state_d = S_IDLE;
         default:            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= S_IDLE;
         rr_q        <= 1'b0;
         buf_v_q     <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_tag_q   <= '0;
         ram_wdata_q <= '0;
         ld_data_q   <= '0;
         if_data_q   <= '0;
         cnt_q       <= 4'd0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         buf_v_q     <= buf_v_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_tag_q   <= ram_tag_d;
         ram_wdata_q <= ram_wdata_d;
         ld_data_q   <= ld_data_d;
         if_data_q   <= if_data_d;
         cnt_q       <= cnt_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // bus result is only offered while the core still wants that word
   assign o_if_valid = hit ||
      (state_q == S_DONE_I && i_if_req && if_tag == ram_tag_q);
   assign o_if_data        = hit ? buf_data_q : if_data_q;
   assign o_mmu_ready      = (state_q == S_DONE_D) ||
                             (state_q != S_DATA && !d_req);
   assign o_mmu_input_data = ld_data_q;
   assign o_ram_addr       = {ram_tag_q, 2'b00};
   assign o_ram_wdata      = ram_wdata_q;
   assign o_ram_en         = ram_en_q;
   assign o_ram_we         = ram_we_q;
   assign o_bus_error      = bus_err_q;
endmodule

// File: tb/tb_rapid_mem_arbiter.sv
// Directed and randomized bench for rapid_mem_arbiter against a
// transaction-level model of arbitration, line buffer and memory.
module tb_rapid_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_req = 1'b0;
   logic [31:0] mmu_addr = '0;
   logic [31:0] mmu_wd = '0;
   logic        mmu_we = 1'b0;
   logic        mmu_re = 1'b0;
   logic [31:0] o_if_data, o_mmu_input_data, o_ram_addr, o_ram_wdata;
   logic        o_if_valid, o_mmu_ready, o_ram_en, o_ram_we, o_bus_error;
   logic        ram_ack;
   logic [31:0] ram_rdata;

   int passed = 0;
   int total = 0;
   int failed = 0;
   int ack_dly = 0;
   bit ack_never = 1'b0;
   int en_cnt;

   logic [31:0] ram_mem [1024];
   bit          ram_wr [1024];
   logic [31:0] mdl_mem [1024];
   bit          mb_v;
   logic [29:0] mb_tag;
   logic [31:0] mb_data;
   bit          mrr;
   logic [31:0] exp_a [$];
   bit          exp_we [$];
   logic [31:0] log_a [$];
   bit          log_we [$];
   bit          en_prev = 1'b0;

   always #5 clk = ~clk;

   rapid_mem_arbiter dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_if_address(if_addr), .i_if_req(if_req),
      .o_if_data(o_if_data), .o_if_valid(o_if_valid),
      .i_mmu_address(mmu_addr), .i_mmu_output_data(mmu_wd),
      .i_mmu_we(mmu_we), .i_mmu_re(mmu_re),
      .o_mmu_input_data(o_mmu_input_data), .o_mmu_ready(o_mmu_ready),
      .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata),
      .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
      .i_ram_rdata(ram_rdata), .i_ram_ack(ram_ack),
      .o_bus_error(o_bus_error)
   );

   function automatic logic [31:0] init_val(int i);
      return (i == 64) ? 32'h00A0_0093 : (32'hC0DE_0000 | 32'(i));
   endfunction

   // RAM: acks on the (ack_dly+1)-th en cycle
   assign ram_ack = o_ram_en && !ack_never && (en_cnt == ack_dly);
   assign ram_rdata = !ram_ack ? 32'hBAD0_BAD0 :
      (ram_wr[o_ram_addr[11:2]] ? ram_mem[o_ram_addr[11:2]]
                                : init_val(int'(o_ram_addr[11:2])));

   always @(posedge clk or negedge rst_n)
      if (!rst_n) en_cnt <= 0;
      else en_cnt <= (o_ram_en && !ram_ack) ? en_cnt + 1 : 0;

   always @(posedge clk)
      if (ram_ack && o_ram_we) begin
         ram_mem[o_ram_addr[11:2]] <= o_ram_wdata;
         ram_wr[o_ram_addr[11:2]]  <= 1'b1;
      end

   always @(posedge clk) begin
      if (o_ram_en && !en_prev) begin
         log_a.push_back(o_ram_addr);
         log_we.push_back(o_ram_we);
      end
      en_prev <= o_ram_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic m_data(input bit st, input logic [29:0] t,
                         input logic [31:0] wd, output logic [31:0] ld);
      mrr = 1'b1;
      exp_a.push_back({t, 2'b00});
      exp_we.push_back(st);
      ld = '0;
      if (st) begin
         if (mb_v && mb_tag == t) mb_v = 1'b0;
         mdl_mem[t[9:0]] = wd;
      end else begin
         ld = mdl_mem[t[9:0]];
      end
   endtask

   task automatic m_fetch(input logic [29:0] t, output logic [31:0] f);
      mrr = 1'b0;
      exp_a.push_back({t, 2'b00});
      exp_we.push_back(1'b0);
      f = mdl_mem[t[9:0]];
      mb_v = 1'b1;
      mb_tag = t;
      mb_data = f;
   endtask

   task automatic round(input bit do_f, input bit do_d, input bit st,
                        input logic [31:0] fa, input logic [31:0] da,
                        input logic [31:0] wd);
      bit fhit, fbus, dfirst, fp, dp;
      logic [29:0] ft, dt;
      logic [31:0] ef, el, gf, gl;
      int base, nf, nd;
      ft = fa[31:2];
      dt = da[31:2];
      ef = '0; el = '0; gf = '0; gl = '0;
      exp_a.delete();
      exp_we.delete();
      fhit = do_f && mb_v && mb_tag == ft && !(do_d && st && dt == ft);
      fbus = do_f && !fhit;
      if (fhit) ef = mb_data;
      dfirst = do_d && !(fbus && mrr);
      if (dfirst) begin
         m_data(st, dt, wd, el);
         if (fbus) m_fetch(ft, ef);
      end else begin
         if (fbus) m_fetch(ft, ef);
         if (do_d) m_data(st, dt, wd, el);
      end
      if_req = do_f;
      if_addr = fa;
      mmu_we = do_d && st;
      mmu_re = do_d && (!st || $urandom_range(0, 1) == 1);
      mmu_addr = da;
      mmu_wd = wd;
      ack_dly = $urandom_range(0, 2);
      base = log_a.size();
      fp = do_f;
      dp = do_d;
      nf = -1;
      nd = -1;
      for (int n = 0; n < 80 && (fp || dp); n++) begin
         #1;
         if (fp && o_if_valid) begin
            fp = 1'b0; nf = n; gf = o_if_data;
         end
         if (dp && o_mmu_ready) begin
            dp = 1'b0; nd = n; gl = o_mmu_input_data;
         end
         cyc();
         if (!fp) if_req = 1'b0;
         if (!dp) begin
            mmu_we = 1'b0;
            mmu_re = 1'b0;
         end
      end
      chk("rnd_done", 32'(fp | dp), 32'd0);
      if (do_f) begin
         chk("rnd_fdata", gf, ef);
         chk("rnd_fhit", 32'(nf == 0), 32'(fhit));
      end
      if (do_d && !st) chk("rnd_ld", gl, el);
      if (do_d && fbus) chk("rnd_order", 32'(nd < nf), 32'(dfirst));
      chk("rnd_nbus", 32'(log_a.size() - base), 32'(exp_a.size()));
      for (int i = 0; i < exp_a.size() && base + i < log_a.size(); i++) begin
         chk("rnd_addr", log_a[base+i], exp_a[i]);
         chk("rnd_we", 32'(log_we[base+i]), 32'(exp_we[i]));
      end
   endtask

   initial begin
      int en_n, err_n;
      logic rdy_e, en_e;
      logic [31:0] dat_e;
      bit df, ff, st;
      int kind;
      for (int i = 0; i < 1024; i++) mdl_mem[i] = init_val(i);

      // reset state
      #3;
      chk("rst_en", 32'(o_ram_en), 32'd0);
      chk("rst_ready", 32'(o_mmu_ready), 32'd1);
      chk("rst_ifv", 32'(o_if_valid), 32'd0);
      chk("rst_err", 32'(o_bus_error), 32'd0);
      chk("rst_ifd", o_if_data, 32'd0);
      chk("rst_mmud", o_mmu_input_data, 32'd0);
      chk("rst_addr", o_ram_addr, 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;

      // fetch miss then buffer hit
      cyc();
      ack_dly = 1;
      if_req = 1'b1;
      if_addr = 32'h100;
      #1 chk("s1_nohit", 32'(o_if_valid), 32'd0);
      cyc();
      chk("s1_en", 32'(o_ram_en), 32'd1);
      chk("s1_addr", o_ram_addr, 32'h100);
      cyc();
      cyc();
      chk("s1_valid", 32'(o_if_valid), 32'd1);
      chk("s1_data", o_if_data, 32'h00A0_0093);
      cyc();
      if_req = 1'b0;
      cyc();
      if_req = 1'b1;
      #1 chk("s1_hit", 32'(o_if_valid), 32'd1);
      chk("s1_hitdata", o_if_data, 32'h00A0_0093);
      cyc();
      chk("s1_nobus", 32'(o_ram_en), 32'd0);
      if_req = 1'b0;

      // store to buffered word invalidates it
      ack_dly = 0;
      cyc();
      mmu_we = 1'b1;
      mmu_addr = 32'h100;
      mmu_wd = 32'hDEAD_BEEF;
      mdl_mem[64] = 32'hDEAD_BEEF;
      #1 chk("s3_busy", 32'(o_mmu_ready), 32'd0);
      cyc();
      chk("s3_we", 32'(o_ram_we), 32'd1);
      chk("s3_wdata", o_ram_wdata, 32'hDEAD_BEEF);
      cyc();
      chk("s3_ready", 32'(o_mmu_ready), 32'd1);
      cyc();
      mmu_we = 1'b0;
      if_req = 1'b1;
      if_addr = 32'h100;
      #1 chk("s3_miss", 32'(o_if_valid), 32'd0);
      cyc();
      chk("s3_refetch", 32'(o_ram_en), 32'd1);
      cyc();
      chk("s3_newdata", o_if_data, 32'hDEAD_BEEF);
      chk("s3_valid", 32'(o_if_valid), 32'd1);
      cyc();
      if_req = 1'b0;

      // contention from reset: data first, then repeat hits buffer
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      if_req = 1'b1;
      if_addr = 32'h104;
      mmu_re = 1'b1;
      mmu_addr = 32'h2000;
      #1 chk("s2_busy", 32'(o_mmu_ready), 32'd0);
      cyc();
      chk("s2_daddr", o_ram_addr, 32'h2000);
      chk("s2_dwe", 32'(o_ram_we), 32'd0);
      cyc();
      chk("s2_dready", 32'(o_mmu_ready), 32'd1);
      chk("s2_ddata", o_mmu_input_data, init_val(0));
      cyc();
      mmu_re = 1'b0;
      cyc();
      chk("s2_iaddr", o_ram_addr, 32'h104);
      chk("s2_ien", 32'(o_ram_en), 32'd1);
      cyc();
      chk("s2_ivalid", 32'(o_if_valid), 32'd1);
      chk("s2_idata", o_if_data, init_val(65));
      cyc();
      if_req = 1'b0;
      cyc();
      if_req = 1'b1;
      mmu_re = 1'b1;
      #1 chk("s2_ifirst", 32'(o_if_valid), 32'd1);
      chk("s2_dwait", 32'(o_mmu_ready), 32'd0);
      cyc();
      if_req = 1'b0;
      chk("s2_daddr2", o_ram_addr, 32'h2000);
      cyc();
      chk("s2_dready2", 32'(o_mmu_ready), 32'd1);
      cyc();
      mmu_re = 1'b0;

      // load timeout
      cyc();
      ack_never = 1'b1;
      mmu_re = 1'b1;
      mmu_addr = 32'h30;
      en_n = 0;
      err_n = 0;
      rdy_e = 1'b0;
      en_e = 1'b1;
      dat_e = 32'hFFFF_FFFF;
      for (int i = 0; i < 40 && err_n == 0; i++) begin
         cyc();
         if (o_ram_en) en_n++;
         if (o_bus_error) begin
            err_n++;
            rdy_e = o_mmu_ready;
            en_e = o_ram_en;
            dat_e = o_mmu_input_data;
         end
      end
      chk("s4_encycles", 32'(en_n), 32'd15);
      chk("s4_err", 32'(err_n), 32'd1);
      chk("s4_ready", 32'(rdy_e), 32'd1);
      chk("s4_endrop", 32'(en_e), 32'd0);
      chk("s4_data", dat_e, 32'd0);
      cyc();
      mmu_re = 1'b0;
      chk("s4_pulse", 32'(o_bus_error), 32'd0);

      // reset during an instruction access
      cyc();
      if_req = 1'b1;
      if_addr = 32'h140;
      cyc();
      cyc();
      chk("s5_en", 32'(o_ram_en), 32'd1);
      rst_n = 1'b0;
      if_req = 1'b0;
      #1 chk("s5_abort", 32'(o_ram_en), 32'd0);
      chk("s5_ready", 32'(o_mmu_ready), 32'd1);
      cyc();
      rst_n = 1'b1;
      ack_never = 1'b0;
      cyc();
      if_req = 1'b1;
      if_addr = 32'h104;
      #1 chk("s5_miss", 32'(o_if_valid), 32'd0);
      cyc();
      chk("s5_bus", o_ram_addr, 32'h104);
      cyc();
      chk("s5_data", o_if_data, init_val(65));
      cyc();
      if_req = 1'b0;

      // back-to-back loads, unaligned byte addresses
      for (int k = 0; k < 2; k++) begin
         cyc();
         mmu_re = 1'b1;
         mmu_addr = (k == 0) ? 32'h13 : 32'h16;
         #1 chk("s6_busy", 32'(o_mmu_ready), 32'd0);
         cyc();
         chk("s6_addr", o_ram_addr, (k == 0) ? 32'h10 : 32'h14);
         cyc();
         chk("s6_ready", 32'(o_mmu_ready), 32'd1);
         chk("s6_data", o_mmu_input_data, init_val(k == 0 ? 4 : 5));
      end
      cyc();
      mmu_re = 1'b0;

      // randomized rounds against the model
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      mb_v = 1'b0;
      mrr = 1'b0;
      cyc();
      for (int r = 0; r < 60; r++) begin
         kind = $urandom_range(0, 4);
         ff = (kind == 0 || kind >= 3);
         df = (kind != 0);
         st = (kind == 2 || kind == 4);
         round(ff, df, st,
               32'h100 + 32'($urandom_range(0, 5) << 2) +
                  32'($urandom_range(0, 3)),
               32'h100 + 32'($urandom_range(0, 7) << 2) +
                  32'($urandom_range(0, 3)),
               $urandom);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
